sprite_line_scan: RTL

Per-scanline sprite scheduler in the `clk_draw` domain that sequences the sprite attribute BRAM. On each `line_start`, it walks the sprite table one entry per cycle by driving the BRAM index. It tests each sprite's vertical extent against the current line and streams hits, with their row offset, to the sprite drawer over a valid/ready handshake. It sits between the video timing generator (line pulses) and the line-buffer drawer.

---
 rtl/sprite_line_scan_pkg.sv | 38 +++
 rtl/sprite_line_scan_hit_test.sv | 20 ++
 rtl/sprite_line_scan.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sprite_line_scan_pkg.sv
// Shared sprite types: BRAM attribute layouts, the emitted hit record and
// the scan FSM state encoding.
package sprite_line_scan_pkg;

    localparam int unsigned LINE_Y_W     = 12;
    localparam int unsigned SPRITE_IDX_W = 9;
    localparam int unsigned SPRITE_X_W   = 12;
    localparam int unsigned SPRITE_AW    = 16;

    // Vertical placement of a sprite; height == 0 marks the end of the table.
    typedef struct packed {
        logic [LINE_Y_W-1:0] y;
        logic [LINE_Y_W-1:0] height;
    } sprite_y_height_t;

    // Horizontal placement, passed straight through to the drawer.
    typedef struct packed {
        logic [SPRITE_X_W-1:0] x;
        logic [SPRITE_X_W-1:0] width;
    } sprite_x_width_t;

    typedef logic [SPRITE_AW-1:0] sprite_addr_t;

    // One sprite found on the current line.
    typedef struct packed {
        logic [SPRITE_IDX_W-1:0] index;
        logic [LINE_Y_W-1:0]     row;
        sprite_x_width_t         x_width;
        sprite_addr_t            addr;
    } sprite_hit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/sprite_line_scan_hit_test.sv
// Wrap-aware vertical hit test: row within the sprite and whether the line
// falls inside it. Modulo-4096 subtraction handles sprites straddling 4095->0.
module sprite_hit_test
    import sprite_line_scan_pkg::*;
(
    input  logic [LINE_Y_W-1:0] line_y,
    input  sprite_y_height_t    y_height,
    output logic [LINE_Y_W-1:0] row,
    output logic                hit,
    output logic                terminator
);

    // Row offset, terminator detect and extent compare.
    always_comb begin
        row        = line_y - y_height.y;
        terminator = (y_height.height == '0);
        hit        = !terminator && (row < y_height.height);
    end

endmodule

// File: rtl/sprite_line_scan.sv
// Per-scanline sprite scheduler: walks the sprite attribute BRAM one entry
// per cycle after line_start and streams vertical hits to the drawer.
module sprite_line_scan
    import sprite_line_scan_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 512,
    parameter int unsigned MAX_HITS    = 64
) (
    input  logic                     clk_draw,
    input  logic                     rst_n,
    input  logic                     line_start,
    input  logic [LINE_Y_W-1:0]      line_y,
    output logic [SPRITE_IDX_W-1:0]  sprite_index,
    input  sprite_y_height_t         sprite_y_height,
    input  sprite_x_width_t          sprite_x_width,
    input  sprite_addr_t             sprite_addr,
    output logic                     hit_valid,
    input  logic                     hit_ready,
    output logic [SPRITE_IDX_W-1:0]  hit_index,
    output logic [LINE_Y_W-1:0]      hit_row,
    output sprite_x_width_t          hit_x_width,
    output sprite_addr_t             hit_addr,
    output logic                     line_done,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(MAX_HITS + 1);

    scan_state_t             state;
    scan_state_t             state_next;
    logic [SPRITE_IDX_W-1:0] eval_idx;
    logic [LINE_Y_W-1:0]     line_y_q;
    logic                    out_valid;
    sprite_hit_t             out_q;
    logic [CNT_W-1:0]        hit_count;
    logic                    overflow_q;

    logic [LINE_Y_W-1:0]     row;
    logic                    is_hit;
    logic                    is_term;
    logic                    scanning;
    logic                    last_entry;
    logic                    at_max;
    logic                    out_blocked;
    logic                    ovf_hit;
    logic                    stall;
    logic                    load;
    logic                    scan_end;

    sprite_hit_test u_hit_test (
        .line_y     (line_y_q),
        .y_height   (sprite_y_height),
        .row        (row),
        .hit        (is_hit),
        .terminator (is_term)
    );

    // Scan control qualifiers for the entry evaluated this cycle.
    always_comb begin
        scanning    = (state == SCAN);
        last_entry  = (eval_idx == SPRITE_IDX_W'(NUM_SPRITES - 1));
        at_max      = (hit_count == CNT_W'(MAX_HITS));
        out_blocked = out_valid && !hit_ready;
        ovf_hit     = scanning && is_hit && at_max;
        stall       = scanning && is_hit && !at_max && out_blocked;
        load        = scanning && is_hit && !at_max && !out_blocked;
        scan_end    = scanning && (ovf_hit || (!stall && (is_term || last_entry)));
    end

    // State register.
    always_ff @(posedge clk_draw or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; line_start from any state (re)starts a scan.
    always_comb begin
        state_next = state;
        if (line_start) begin
            state_next = SCAN;
        end else begin
            case (state)
                SCAN:    if (scan_end) state_next = DRAIN;
                DRAIN:   if (!out_valid) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs; the read address is held while stalled so BRAM data keeps
    // matching eval_idx without any replay.
    always_comb begin
        busy      = (state != IDLE);
        line_done = (state == DRAIN) && !out_valid && !line_start;
        if (scanning && !line_start) begin
            sprite_index = stall ? eval_idx : eval_idx + SPRITE_IDX_W'(1);
        end else begin
            sprite_index = '0;
        end
        hit_valid   = out_valid;
        hit_index   = out_q.index;
        hit_row     = out_q.row;
        hit_x_width = out_q.x_width;
        hit_addr    = out_q.addr;
        overflow    = overflow_q;
    end

    // Datapath: entry counter, single-entry output register, hit counting.
    always_ff @(posedge clk_draw or negedge rst_n) begin
        if (!rst_n) begin
            eval_idx   <= '0;
            line_y_q   <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
            hit_count  <= '0;
            overflow_q <= 1'b0;
        end else if (line_start) begin
            eval_idx   <= '0;
            line_y_q   <= line_y;
            out_valid  <= 1'b0;
            hit_count  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (scanning && !stall) begin
                eval_idx <= eval_idx + SPRITE_IDX_W'(1);
            end
            if (load) begin
                out_valid <= 1'b1;
                out_q     <= '{index: eval_idx, row: row,
                               x_width: sprite_x_width, addr: sprite_addr};
                hit_count <= hit_count + CNT_W'(1);
            end else if (out_valid && hit_ready) begin
                out_valid <= 1'b0;
            end
            if (ovf_hit) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
